// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    // Supervisor sequencing states.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_sup_state_t;

    // Saturation ceiling of the lock-loss counter.
    localparam logic [7:0] LOCK_LOST_MAX = 8'hFF;

    // Width of the shared cycle counter. The counter never has to hold the
    // largest period itself, only that value minus one. The result is
    // clamped to one bit so that all-ones-cycle configurations still work.
    function automatic int pll_sup_cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// N-flop single-bit synchroniser with asynchronous active-low clear.
module pll_sup_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the system PLL from the reference clock: pulses the PLL reset,
// waits for lock with retry on timeout, requires lock to be stable before
// releasing core reset, and restarts the sequence when lock is lost.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE    = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 7,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_lost_cnt
);

    localparam int CNT_W = pll_sup_cnt_width(RST_PULSE, LOCK_STABLE, LOCK_TIMEOUT);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    pll_sup_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       lost_q, lost_d;
    logic             pll_rst_q, core_reset_q, ready_q, fail_q;
    logic             locked_s;

    pll_sup_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (locked),
        .q_o    (locked_s)
    );

    // Next-state, retry and lock-loss bookkeeping; soft_reset overrides all.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        if (soft_reset) begin
            state_d = RESET_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    // A lock seen on the timeout cycle still counts as a lock.
                    if (locked_s) begin
                        state_d = STABILIZE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = FAIL;
                        end else begin
                            retry_d = retry_q + 4'd1;
                            state_d = RESET_PLL;
                        end
                    end
                end
                STABILIZE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d = RESET_PLL;
                        if (lost_q != LOCK_LOST_MAX) lost_d = lost_q + 8'd1;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = RESET_PLL;
                end
            endcase
        end
    end

    // Shared cycle counter: restarts on every state entry (and on soft_reset),
    // and only runs in the states that time something.
    always_comb begin
        cnt_d = cnt_q;
        if (soft_reset || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((state_q == RESET_PLL) || (state_q == WAIT_LOCK) ||
                     (state_q == STABILIZE)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State register plus outputs decoded from the next state, so every
    // output is a flop and tracks the state register exactly.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_PLL;
            cnt_q        <= '0;
            retry_q      <= '0;
            lost_q       <= '0;
            pll_rst_q    <= 1'b1;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            lost_q       <= lost_d;
            pll_rst_q    <= (state_d == RESET_PLL);
            core_reset_q <= (state_d != RUN);
            ready_q      <= (state_d == RUN);
            fail_q       <= (state_d == FAIL);
        end
    end

    assign pll_rst       = pll_rst_q;
    assign core_reset    = core_reset_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign retry_cnt     = retry_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the system PLL and releases core reset. Runs on the 50 MHz reference clock, so it stays alive while the PLL output is absent or unstable. It drives the PLL's active-high reset, monitors its asynchronous `locked` output, retries on lock timeout, and holds `core_reset` until lock has been stable for a programmable time. Sits between the board reset/reference clock and the PLL wrapper; `core_reset` feeds the per-domain reset synchronisers of the core.

## Interface
- `RST_PULSE`, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- `LOCK_STABLE`, 1024: consecutive synchronised-locked cycles required before release (≥1).
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock before retrying (≥2).
- `MAX_RETRY`, 7: retries after the first attempt before declaring failure (≤15).
- `SYNC_STAGES`, 2: flops on the `locked` synchroniser (≥2).

Ports:
- `refclk`  in  1  50 MHz reference clock; sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `locked`  in  1  PLL lock, asynchronous to `refclk`.
- `soft_reset`  in  1  synchronous request; restarts the sequence (one-cycle pulse or level).
- `pll_rst`  out  1  active-high PLL reset.
- `core_reset`  out  1  active-high core reset; low only in RUN.
- `ready`  out  1  high only in RUN.
- `fail`  out  1  high only in FAIL.
- `retry_cnt`  out  4  retries consumed in the current sequence.
- `lock_lost_cnt`  out  8  lock losses seen in RUN; saturates at 255.

## Operation
- `locked` passes through a `SYNC_STAGES`-flop synchroniser to give `locked_s`. The FSM uses only `locked_s`.
- States, with one shared cycle counter `cnt` that is cleared on every state entry:
  - **RESET_PLL**: `pll_rst=1`. After `cnt==RST_PULSE-1`, go to WAIT_LOCK.
  - **WAIT_LOCK**: if `locked_s`, go to STABILIZE. Otherwise, on `cnt==LOCK_TIMEOUT-1`:
    - if `retry_cnt==MAX_RETRY`, go to FAIL;
    - else `retry_cnt++` and go to RESET_PLL.
    - If lock and timeout occur in the same cycle, lock wins.
  - **STABILIZE**: `locked_s` low → WAIT_LOCK (timeout restarts from 0). `locked_s` high with `cnt==LOCK_STABLE-1` → RUN.
  - **RUN**: `retry_cnt` cleared on entry. `locked_s` low → `lock_lost_cnt++` (saturating) and go to RESET_PLL.
  - **FAIL**: `pll_rst=0`, `core_reset=1`. Leaves only on `soft_reset` or `rst_n`.
- `soft_reset` in any state:
  - go to RESET_PLL, clear `retry_cnt` and `cnt`;
  - `lock_lost_cnt` is not changed;
  - `soft_reset` has priority over every other transition, including a simultaneous lock loss in RUN (no increment in that case).
- Outputs are Moore-decoded from the state register, with no combinational path from inputs. `pll_rst=1` only in RESET_PLL.
- `lock_lost_cnt` is cleared only by `rst_n`.

## Timing
- **Reset values** (`rst_n` low, applied asynchronously):
  - state = RESET_PLL, `cnt=0`;
  - `pll_rst=1`, `core_reset=1`, `ready=0`, `fail=0`;
  - `retry_cnt=0`, `lock_lost_cnt=0`, synchroniser cleared.
- **Reset mid-operation**: the next cycle after `rst_n` deassertion begins a fresh RESET_PLL.
- **PLL reset pulse**: `pll_rst` is high for exactly `RST_PULSE` cycles per attempt.
- **Lock to release**: call the first edge that samples `locked` high edge 0. With `locked` held high, the state becomes RUN at edge `SYNC_STAGES+LOCK_STABLE`. `core_reset` falls and `ready` rises on that same edge.
- **Lock loss**: call the first edge that samples `locked` low edge 0. The state leaves RUN at edge `SYNC_STAGES`. `ready` falls and `core_reset` and `pll_rst` rise on that edge.
- **Time to failure**: from `rst_n` release to FAIL, with no lock ever seen, is `(MAX_RETRY+1)·(RST_PULSE+LOCK_TIMEOUT)` cycles.

## Structure
- Package `pll_sup_pkg`:
  - state enum `pll_sup_state_t` (RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAIL);
  - counter-width function `$clog2(max(RST_PULSE, LOCK_STABLE, LOCK_TIMEOUT))`.
- Sub-module `pll_sup_sync`: parameterised N-flop bit synchroniser with async active-low clear. `pll_lock_supervisor` instantiates it once for `locked`.

## Test plan
Parameters RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2, SYNC_STAGES=2 unless noted.
- **Normal lock**: release `rst_n`; `locked` rises at cycle 20 → `pll_rst` high cycles 0–3. `ready=1` and `core_reset=0` exactly 10 edges after the first high sample.
- **No lock**: `locked` never rises → 3 `pll_rst` pulses. FAIL at cycle 108 with `fail=1`, `retry_cnt=2`, `pll_rst=0`. A `soft_reset` pulse then gives `pll_rst=1` and `retry_cnt=0`.
- **Stabilize glitch**: `locked` dips low for 1 cycle 5 cycles into STABILIZE → back to WAIT_LOCK. RUN reached 10 edges after the recovered high sample, with `retry_cnt` unchanged.
- **Lock loss in RUN**: drop `locked` → `ready` falls 2 edges later, `lock_lost_cnt=1`, and a 4-cycle `pll_rst` pulse follows. A simultaneous `soft_reset` instead leaves `lock_lost_cnt=0`.
- **Counter saturation**: force 300 lock losses → `lock_lost_cnt` holds at 255.
- **Async reset mid-STABILIZE**: assert `rst_n` low asynchronously (not on an edge) → all outputs take their reset values immediately; the sequence restarts after release.
